bp_update_ctrl: RTL

//  Update scheduler for the branch predictor. Two producers report resolved branches:
//    - port A: EX stage, all branches, with the prediction made in IF.
//    - port B: ID stage, early direct-jump reports.

---
 rtl/bp_update_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bp_update_ctrl.sv
// -----------------------------------------------------------------------------
// bp_update_ctrl
// Schedules branch-predictor updates from two producers.
//   Port A (EX stage) reports every resolved branch together with the IF
//   prediction. Port B (ID stage) reports direct jumps early.
// Accepted records are queued in a small FIFO. The FIFO head drives the
// predictor update port at up to one record per cycle. A mispredicted A record
// also produces a registered one-cycle IF redirect.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   a_valid/a_ready        EX record handshake
//   a_addr, a_cond, a_taken, a_target, a_pred_taken, a_pred_target
//                          EX record fields and the prediction made in IF
//   b_valid/b_ready        ID direct-jump handshake
//   b_addr, b_target       ID jump fields
//   hold                   pause draining
//   flush                  discard every queued record
//   upd_*                  predictor update port, driven from the FIFO head
//   redirect_valid/_pc     one-cycle IF redirect after an A mispredict
//   q_count                FIFO occupancy
// -----------------------------------------------------------------------------
module bp_update_ctrl #(
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 3
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     a_valid,
   output logic                     a_ready,
   input  logic [31:0]              a_addr,
   input  logic                     a_cond,
   input  logic                     a_taken,
   input  logic [31:0]              a_target,
   input  logic                     a_pred_taken,
   input  logic [31:0]              a_pred_target,
   input  logic                     b_valid,
   output logic                     b_ready,
   input  logic [31:0]              b_addr,
   input  logic [31:0]              b_target,
   input  logic                     hold,
   input  logic                     flush,
   output logic                     upd_en,
   output logic [31:0]              upd_inst_addr,
   output logic                     upd_br_inst,
   output logic                     upd_cond_br_inst,
   output logic                     upd_br_taken,
   output logic [31:0]              upd_br_target,
   output logic                     redirect_valid,
   output logic [31:0]              redirect_pc,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [31:0]     redirect_pc_q, redirect_pc_d;

   logic [31:0]     mem_addr_q   [DEPTH];
   logic            mem_cond_q   [DEPTH];
   logic            mem_taken_q  [DEPTH];
   logic [31:0]     mem_target_q [DEPTH];

   logic [PW-1:0]   count_s;
   logic            free_s;
   logic            blocked_s;
   logic            starved_s;
   logic            b_win_s;
   logic            a_win_s;
   logic            a_fire_s;
   logic            b_fire_s;
   logic            enq_s;
   logic            deq_s;
   logic            clear_s;
   logic            mispredict_s;
   logic [AW-1:0]   wr_idx_s;
   logic [AW-1:0]   rd_idx_s;
   logic [31:0]     enq_addr_s;
   logic            enq_cond_s;
   logic            enq_taken_s;
   logic [31:0]     enq_target_s;

   // Occupancy comes from the extra pointer bit, so full and empty differ.
   assign count_s   = wr_ptr_q - rd_ptr_q;
   assign free_s    = (count_s < PW'(DEPTH));
   assign wr_idx_s  = wr_ptr_q[AW-1:0];
   assign rd_idx_s  = rd_ptr_q[AW-1:0];
   assign blocked_s = (state_q == ST_FLUSH) || flush;
   assign starved_s = (starve_q == SW'(STARVE_LIM));
   assign clear_s   = (state_q == ST_FLUSH) || flush;

   assign mispredict_s = (a_pred_taken != a_taken) ||
                         (a_taken && (a_pred_target != a_target));

   // Arbitration, handshakes and the enqueue record mux
   always_comb begin
      b_win_s  = b_valid && (!a_valid || starved_s);
      a_win_s  = a_valid && !b_win_s;
      a_ready  = a_win_s && free_s && !blocked_s;
      b_ready  = b_win_s && free_s && !blocked_s;
      a_fire_s = a_valid && a_ready;
      b_fire_s = b_valid && b_ready;
      enq_s    = a_fire_s || b_fire_s;
      deq_s    = (state_q == ST_RUN) && (count_s != '0) && !flush;
      if (a_fire_s) begin
         enq_addr_s   = a_addr;
         enq_cond_s   = a_cond;
         enq_taken_s  = a_taken;
         enq_target_s = a_target;
      end else begin
         // Direct jumps are unconditional and always taken.
         enq_addr_s   = b_addr;
         enq_cond_s   = 1'b0;
         enq_taken_s  = 1'b1;
         enq_target_s = b_target;
      end
   end

   // Control FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (flush)      state_d = ST_FLUSH;
            else if (hold)  state_d = ST_HOLD;
            else            state_d = ST_RUN;
         end
         ST_HOLD: begin
            if (flush)      state_d = ST_FLUSH;
            else if (!hold) state_d = ST_RUN;
            else            state_d = ST_HOLD;
         end
         ST_FLUSH: begin
            if (hold)       state_d = ST_HOLD;
            else            state_d = ST_RUN;
         end
         default:           state_d = ST_RUN;
      endcase
   end

   // Pointer and starvation counter next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      starve_d = starve_q;
      // Clearing already while flush is high makes the queue read empty in
      // the FLUSH cycle; the FLUSH edge itself clears it again.
      if (clear_s) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (enq_s) wr_ptr_d = wr_ptr_q + PW'(1);
         else       wr_ptr_d = wr_ptr_q;
         if (deq_s) rd_ptr_d = rd_ptr_q + PW'(1);
         else       rd_ptr_d = rd_ptr_q;
      end
      if (state_q == ST_FLUSH || b_fire_s) begin
         starve_d = '0;
      end else if (b_valid && a_fire_s && !starved_s) begin
         starve_d = starve_q + SW'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   // Redirect next state; the PC holds when no redirect fires
   always_comb begin
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      if (a_fire_s && mispredict_s) begin
         redirect_valid_d = 1'b1;
         redirect_pc_d    = a_taken ? a_target : (a_addr + 32'h0000_0004);
      end else begin
         redirect_valid_d = 1'b0;
         redirect_pc_d    = redirect_pc_q;
      end
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q          <= ST_RUN;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         starve_q         <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= 32'h0000_0000;
      end else begin
         state_q          <= state_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         starve_q         <= starve_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   // FIFO storage; contents are only observed through valid pointers
   always_ff @(posedge clk) begin
      if (enq_s && !clear_s) begin
         mem_addr_q[wr_idx_s]   <= enq_addr_s;
         mem_cond_q[wr_idx_s]   <= enq_cond_s;
         mem_taken_q[wr_idx_s]  <= enq_taken_s;
         mem_target_q[wr_idx_s] <= enq_target_s;
      end
   end

   // Update port: head fields are forced to zero while no update is issued
   always_comb begin
      upd_en           = deq_s;
      upd_br_inst      = 1'b0;
      upd_inst_addr    = 32'h0000_0000;
      upd_cond_br_inst = 1'b0;
      upd_br_taken     = 1'b0;
      upd_br_target    = 32'h0000_0000;
      if (deq_s) begin
         upd_br_inst      = 1'b1;
         upd_inst_addr    = mem_addr_q[rd_idx_s];
         upd_cond_br_inst = mem_cond_q[rd_idx_s];
         upd_br_taken     = mem_taken_q[rd_idx_s];
         upd_br_target    = mem_target_q[rd_idx_s];
      end else begin
         upd_br_inst      = 1'b0;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign q_count        = count_s;

endmodule
